// File: rtl/im_loader.sv
// Boot-time instruction memory loader: receives a header byte and a big-endian
// byte stream over valid/ready, then issues one write strobe per assembled word.
module im_loader #(
  parameter int NMEM = 128,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_BYTES = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Header holds (words - 1), so the largest legal value is NMEM-1.
  localparam logic [8:0] MAX_HDR = 9'(NMEM - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [AW-1:0] last_q, last_d;

  logic xfer;
  logic hdr_ok;

  assign xfer   = in_valid & in_ready;
  assign hdr_ok = ({1'b0, in_data} <= MAX_HDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      waddr_q    <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      byte_idx_q <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          count_d    = '0;
          waddr_d    = '0;
          byte_idx_d = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (hdr_ok) begin
            last_d  = in_data[AW-1:0];
            state_d = S_BYTES;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_BYTES: begin
        if (xfer) begin
          wdata_d    = {wdata_q[23:0], in_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        count_d    = count_q + {{AW{1'b0}}, 1'b1};
        byte_idx_d = '0;
        if (waddr_q == last_q) begin
          state_d = S_DONE;
        end else begin
          waddr_d = waddr_q + {{(AW-1){1'b0}}, 1'b1};
          state_d = S_BYTES;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All handshake/status outputs decode from state alone.
  always_comb begin
    in_ready = 1'b0;
    we       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_HDR:   begin in_ready = 1'b1; busy = 1'b1; end
      S_BYTES: begin in_ready = 1'b1; busy = 1'b1; end
      S_WRITE: begin we = 1'b1; busy = 1'b1; end
      S_DONE:  done = 1'b1;
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign count = count_q;

endmodule
